// File: rtl/ram_ctrl_pkg.sv
// Shared constants and state encoding for the two-requester RAM controller.
package ram_ctrl_pkg;

    localparam int NREQ       = 2;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester that is not last wins.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o    = 2'b00;
        grant_o[0] = valid_i[0] & (~valid_i[1] | last_i);
        grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin controller for a single-port synchronous RAM with
// two valid/ready requesters and per-requester completion pulses.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    ram_cs,
    output logic                    ram_we,
    output logic                    ram_oe,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    inout  wire  [DATA_WIDTH-1:0]   ram_data
);

    state_e                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    id_q, id_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    cs_q, cs_d;
    logic                    we_q, we_d;
    logic                    oe_q, oe_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0]         grant;
    logic                    gid;
    logic                    accept;
    logic                    g_we;
    logic [ADDR_WIDTH-1:0]   g_addr;
    logic [DATA_WIDTH-1:0]   g_wdata;

    rr_arbiter2 u_rr (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Ready is held low while reset is asserted even though state reads IDLE.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign accept    = |req_ready;
    assign gid       = grant[1];
    assign g_we      = req_we[gid];
    assign g_addr    = gid ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : req_addr[ADDR_WIDTH-1:0];
    assign g_wdata   = gid ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                           : req_wdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            wdata_q     <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = g_we ? WR : RD_ADDR;
                end
            end
            WR:      state_d = IDLE;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM pins are registered off the next state so they line up with it.
    always_comb begin
        last_d      = last_q;
        id_d        = id_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            last_d  = gid;
            id_d    = gid;
            wdata_d = g_wdata;
            addr_d  = g_addr;
        end
        if (state_q == WR || state_q == RD_DATA) begin
            rsp_valid_d[id_q] = 1'b1;
        end
        if (state_q == RD_DATA) begin
            rsp_rdata_d = ram_data;
        end
        cs_d = (state_d != IDLE);
        we_d = (state_d == WR);
        oe_d = (state_d == RD_ADDR) || (state_d == RD_DATA);
    end

    assign ram_data  = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_cs    = cs_q;
    assign ram_we    = we_q;
    assign ram_oe    = oe_q;
    assign ram_addr  = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [15:0] rsp_rdata;
    wire         ram_cs;
    wire         ram_we;
    wire         ram_oe;
    wire  [3:0]  ram_addr;
    wire  [15:0] ram_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    // Synchronous RAM: registers read data, drives it while oe stays high.
    logic [15:0] mem [16];
    logic [15:0] rd_q;
    logic        rd_v = 1'b0;

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        rd_v <= ram_cs && ram_oe && !ram_we;
        if (ram_cs && ram_oe && !ram_we) rd_q <= mem[ram_addr];
    end

    assign ram_data = (ram_oe && rd_v) ? rd_q : 16'hzzzz;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int id, input bit v, input bit we,
                           input logic [3:0] a, input logic [15:0] d);
        req_valid[id]          = v;
        req_we[id]             = we;
        req_addr[id*4 +: 4]    = a;
        req_wdata[id*16 +: 16] = d;
    endtask

    task automatic wait_ready(input int id, input string nm, output bit ok);
        int n = 0;
        #1;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = req_ready[id];
        chk({nm, ".ready"}, 32'(ok), 32'd1);
    endtask

    task automatic txn(input int id, input bit we, input logic [3:0] a,
                       input logic [15:0] d, input logic [15:0] exp,
                       input string nm);
        bit ok;
        logic [1:0] oh;
        oh = (id == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        set_req(id, 1'b1, we, a, d);
        wait_ready(id, nm, ok);
        if (!ok) begin
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        @(negedge clk);
        chk({nm, ".ctl"}, {ram_cs, ram_we, ram_oe, ram_addr},
            {1'b1, we, !we, a});
        chk({nm, ".rsp0"}, rsp_valid, 2'b00);
        @(negedge clk);
        if (we) begin
            chk({nm, ".wrsp"}, rsp_valid, oh);
            chk({nm, ".wcs"}, ram_cs, 1'b0);
        end else begin
            chk({nm, ".rsp1"}, rsp_valid, 2'b00);
            chk({nm, ".oe1"}, ram_oe, 1'b1);
            @(negedge clk);
            chk({nm, ".rrsp"}, rsp_valid, oh);
            chk({nm, ".rdata"}, rsp_rdata, exp);
            chk({nm, ".idle"}, {ram_cs, ram_oe}, 2'b00);
        end
    endtask

    typedef struct {
        int          id;
        bit          we;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t        vt[8];
    logic [15:0] sw[16];

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int n;
        logic [1:0] g;

        vt[0] = '{0, 1'b1, 4'd3,  16'hA5A5, 16'h0000};
        vt[1] = '{0, 1'b0, 4'd3,  16'h0000, 16'hA5A5};
        vt[2] = '{1, 1'b1, 4'd0,  16'h0F0F, 16'h0000};
        vt[3] = '{0, 1'b0, 4'd0,  16'h0000, 16'h0F0F};
        vt[4] = '{1, 1'b1, 4'd15, 16'hFFFF, 16'h0000};
        vt[5] = '{1, 1'b0, 4'd15, 16'h0000, 16'hFFFF};
        vt[6] = '{0, 1'b1, 4'd3,  16'h5A5A, 16'h0000};
        vt[7] = '{1, 1'b0, 4'd3,  16'h0000, 16'h5A5A};

        rst = 1'b1;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rst.ready", req_ready, 2'b00);
        chk("rst.rsp", rsp_valid, 2'b00);
        chk("rst.rdata", rsp_rdata, 16'h0000);
        chk("rst.ctl", {ram_cs, ram_we, ram_oe}, 3'b000);
        chk("rst.addr", ram_addr, 4'h0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            txn(vt[i].id, vt[i].we, vt[i].a, vt[i].d, vt[i].exp,
                $sformatf("vec%0d", i));
        end

        // Reset asserted while the read sits in RD_ADDR.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd9, 16'h0);
        wait_ready(0, "rstmid", ok);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rstmid.cs_pre", ram_cs, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid.ctl", {ram_cs, ram_we, ram_oe}, 3'b000);
        chk("rstmid.rsp", rsp_valid, 2'b00);
        @(negedge clk);
        chk("rstmid.rsp2", rsp_valid, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid.rsp3", rsp_valid, 2'b00);
        req_valid[0] = 1'b1;
        #1;
        chk("rstmid.idle", req_ready, 2'b01);
        req_valid[0] = 1'b0;

        // Contention from a fresh reset: grants alternate 0,1,0,1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'd4, 16'h1111);
        set_req(1, 1'b1, 1'b1, 4'd5, 16'h2222);
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            g = req_ready;
            chk("cont.both", 32'(req_ready == 2'b11), 32'd0);
            chk($sformatf("cont.grant%0d", k), g,
                (k % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("cont.rsp0", rsp_valid, 2'b00);
            @(negedge clk);
            #1;
            chk($sformatf("cont.rsp%0d", k), rsp_valid, g);
        end
        req_valid = '0;
        txn(0, 1'b0, 4'd5, 16'h0, 16'h2222, "cont.rd5");
        txn(1, 1'b0, 4'd4, 16'h0, 16'h1111, "cont.rd4");
        txn(0, 1'b1, 4'd15, 16'h0000, 16'h0, "xo.pre");

        // Requester 1 wins, writes 15, then requester 0 reads it back.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd15, 16'h0);
        set_req(1, 1'b1, 1'b1, 4'd15, 16'h1234);
        #1;
        chk("xo.grant", req_ready, 2'b10);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("xo.wctl", {ram_cs, ram_we, ram_addr}, {2'b11, 4'd15});
        @(negedge clk);
        chk("xo.wrsp", rsp_valid, 2'b10);
        chk("xo.ready0", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("xo.r0", rsp_valid, 2'b00);
        @(negedge clk);
        chk("xo.r1", rsp_valid, 2'b00);
        @(negedge clk);
        chk("xo.rrsp", rsp_valid, 2'b01);
        chk("xo.rdata", rsp_rdata, 16'h1234);

        for (int i = 0; i < 16; i++) begin
            sw[i] = 16'($urandom);
            txn(0, 1'b1, 4'(i), sw[i], 16'h0, $sformatf("sw.wr%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            txn(1, 1'b0, 4'(i), 16'h0, sw[i], $sformatf("sw.rd%0d", i));
        end
        txn(0, 1'b1, 4'd2, 16'hC0DE, 16'h0, "sw.wrafter");

        // Requester 1 flickers valid during a read and must be ignored.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd3, 16'h0);
        wait_ready(0, "wd", ok);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b1, 4'd7, 16'hBEEF);
        @(negedge clk);
        chk("wd.ready_a", req_ready, 2'b00);
        @(negedge clk);
        chk("wd.ready_b", req_ready, 2'b00);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("wd.rsp", rsp_valid, 2'b01);
        chk("wd.rdata", rsp_rdata, sw[3]);
        chk("wd.ready_c", req_ready, 2'b00);
        @(negedge clk);
        chk("wd.rsp_after", rsp_valid, 2'b00);
        txn(1, 1'b0, 4'd7, 16'h0, sw[7], "wd.rd7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
